serial_adder: RTL and testbench

- Bit-serial N-bit adder; the addition counterpart of the team's combinational half-subtractor cells.
- Each cycle it consumes one operand bit pair, LSB first, through a full-adder cell built from two half-adder stages, with a registered carry.
- Start/busy/done handshake so that a controller can trade area for latency in wide arithmetic datapaths.

---
 rtl/serial_arith_pkg.sv | 16 +
 rtl/serial_adder_if.sv | 24 ++
 rtl/serial_adder_half_add_bit.sv | 10 +
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder now, subtractor later).
// Holds the control-state encoding and the bit-counter sizing helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to index operand bits 0..width-1; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// The master issues operands and start; the slave returns status and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_half_add_bit.sv
// Single-bit half adder; two of these plus an OR make the per-bit full adder.
module half_add_bit (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock, LSB first, registered carry.
// sum/cout update only on the last RUN edge, so they always show a complete result.
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  serial_adder_if.slave  bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-2:0] part_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg, cout_reg;
  logic [CW-1:0]    count_reg;

  logic             load, last;
  logic             p_bit, g_bit, bit_s, c_prop, bit_c;
  logic [WIDTH-1:0] part_next;

  // Full adder: generate/propagate from the operands, then fold in the carry.
  half_add_bit u_ha_ops (.x(a_reg[0]), .y(b_reg[0]), .s(p_bit), .c(g_bit));
  half_add_bit u_ha_cry (.x(p_bit), .y(carry_reg), .s(bit_s), .c(c_prop));
  assign bit_c = g_bit | c_prop;

  assign last      = (count_reg == LAST_BIT);
  assign part_next = {bit_s, part_reg};

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = RUN;
          load       = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      part_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        a_reg     <= bus.a;
        b_reg     <= bus.b;
        carry_reg <= bus.cin;
        count_reg <= '0;
      end else if (state_reg == RUN) begin
        a_reg     <= a_reg >> 1;
        b_reg     <= b_reg >> 1;
        part_reg  <= part_next[WIDTH-1:1];
        carry_reg <= bit_c;
        count_reg <= count_reg + 1'b1;
        if (last) begin
          sum_reg  <= part_next;
          cout_reg <= bit_c;
        end
      end
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus a WIDTH=4 exhaustive sweep.
// Stimulus pushes expected {cout,sum}; per-DUT monitors pop and compare on every done pulse.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic       prev_done8 = 1'b0;
  logic       prev_done4 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare every completed result against the scoreboard head.
  always @(negedge clk) begin
    logic [8:0] exp8;
    if (if8.done) begin
      check("w8_done_busy_overlap", {31'd0, if8.busy}, 32'd0);
      check("w8_done_width", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        check("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp8 = q8.pop_front();
        check("w8_result", {23'd0, if8.cout, if8.sum}, {23'd0, exp8});
        $display("w8 result cout=%0d sum=0x%02h expected cout=%0d sum=0x%02h",
                 if8.cout, if8.sum, exp8[8], exp8[7:0]);
      end
    end
    prev_done8 = if8.done;
  end

  always @(negedge clk) begin
    logic [4:0] exp4;
    if (if4.done) begin
      check("w4_done_busy_overlap", {31'd0, if4.busy}, 32'd0);
      check("w4_done_width", {31'd0, prev_done4}, 32'd0);
      if (q4.size() == 0) begin
        check("w4_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp4 = q4.pop_front();
        check("w4_result", {27'd0, if4.cout, if4.sum}, {27'd0, exp4});
        $display("w4 result cout=%0d sum=0x%0h expected cout=%0d sum=0x%0h",
                 if4.cout, if4.sum, exp4[4], exp4[3:0]);
      end
    end
    prev_done4 = if4.done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One start on the WIDTH=8 DUT, then measure busy length and done position.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [8:0] exp, input string tag);
    int busy_cyc;
    int done_cyc;
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.cin = cin;
    q8.push_back(exp);
    busy_cyc = 0;
    done_cyc = 0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) if8.start = 1'b0;
      if (if8.busy) busy_cyc++;
      if (if8.done && done_cyc == 0) done_cyc = i;
    end
    check({tag, "_busy_cycles"}, busy_cyc, 32'd8);
    check({tag, "_done_cycle"}, done_cyc, 32'd9);
  endtask

  initial begin
    int busy_cnt;
    int done_a;
    int done_b;
    int hold_bad;
    int waited;
    logic [4:0] e4;

    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, if8.busy}, 32'd0);
    check("reset_done", {31'd0, if8.done}, 32'd0);
    check("reset_result", {23'd0, if8.cout, if8.sum}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic additions and carry-out boundaries
    run8(8'h25, 8'h3A, 1'b0, 9'h05F, "add_25_3a");
    run8(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    run8(8'hFF, 8'h00, 1'b1, 9'h100, "add_ff_00_cin");

    // Ignored start mid-run, then back-to-back start held through done
    if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
    q8.push_back(9'h030);
    busy_cnt = 0; done_a = 0; done_b = 0; hold_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (if8.busy && i <= 8) busy_cnt++;
      if (if8.done && i <= 9 && done_a == 0) done_a = i;
      if (if8.done && i > 9 && done_b == 0) done_b = i;
      if (i >= 10 && i <= 17 && {if8.cout, if8.sum} !== 9'h030) hold_bad++;
      if (i == 9) check("b2b_first_sum", {23'd0, if8.cout, if8.sum}, 32'h030);
      case (i)
        1: if8.start = 1'b0;
        2: begin if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.cin = 1'b1; end
        3: begin if8.start = 1'b0; if8.a = 8'h33; if8.b = 8'h44; end
        8: begin
          if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0;
          q8.push_back(9'h100);
        end
        10: if8.start = 1'b0;
        default: ;
      endcase
    end
    check("ignore_busy_cycles", busy_cnt, 32'd8);
    check("ignore_done_cycle", done_a, 32'd9);
    check("b2b_second_done_cycle", done_b, 32'd18);
    check("b2b_sum_hold", hold_bad, 32'd0);

    // Asynchronous reset in the middle of a run
    if8.start = 1'b1; if8.a = 8'h7F; if8.b = 8'h01; if8.cin = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) if8.start = 1'b0;
    end
    check("pre_reset_busy", {31'd0, if8.busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, if8.busy}, 32'd0);
    check("async_rst_done", {31'd0, if8.done}, 32'd0);
    check("async_rst_result", {23'd0, if8.cout, if8.sum}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_idle_busy", {31'd0, if8.busy}, 32'd0);
    run8(8'h7F, 8'h01, 1'b0, 9'h080, "add_7f_01_after_rst");

    // Exhaustive WIDTH=4 sweep, each start issued in the previous done cycle
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          if4.start = 1'b1;
          if4.a = 4'(ai); if4.b = 4'(bi); if4.cin = 1'(ci);
          e4 = 5'(ai + bi + ci);
          q4.push_back(e4);
          @(negedge clk);
          if4.start = 1'b0;
          waited = 0;
          while (!if4.done && waited < 10) begin
            @(negedge clk);
            waited++;
          end
          if (!if4.done) begin
            check("w4_done_timeout", 32'd1, 32'd0);
            @(negedge clk);
          end
        end
      end
    end
    @(negedge clk);
    @(negedge clk);

    check("w8_queue_drained", q8.size(), 32'd0);
    check("w4_queue_drained", q4.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
